// File: rtl/tmr_fault_campaign_ctrl.sv
// tmr_fault_campaign_ctrl: steps a TMR unit through all 8 fault-injection masks
// and records a per-mask pass bit plus a saturating count of flagged cycles.
module tmr_fault_campaign_ctrl #(
    parameter int DATA_LEN   = 27,
    parameter int SETTLE_CYC = 4,
    parameter int OBS_CYC    = 8,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [DATA_LEN-1:0] golden_in,
    input  logic [DATA_LEN-1:0] tmr_data_in,
    input  logic                tmr_error_in,
    output logic                tmr_rst,
    output logic                A_error_ctrl,
    output logic                B_error_ctrl,
    output logic                C_error_ctrl,
    output logic                busy,
    output logic                done,
    output logic [7:0]          pass_mask,
    output logic [CNT_W-1:0]    err_count
);
    localparam int MAXC = SETTLE_CYC > OBS_CYC ? SETTLE_CYC : OBS_CYC;
    localparam int CW   = $clog2(MAXC) + 1;

    typedef enum logic [2:0] {IDLE, TRST, SETTLE, INJECT, EVAL, DONE} state_t;

    state_t          state, state_nx;
    logic [2:0]      step, step_nx, ctrl, ctrl_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            seen_err, seen_err_nx, seen_bad, seen_bad_nx;
    logic            tmr_rst_nx, busy_nx, done_nx, exp_err;
    logic [7:0]      pass_nx;
    logic [CNT_W-1:0] err_nx;

    // two or more faulty replicas must be flagged; a single one must be voted out
    assign exp_err = (step[0] & step[1]) | (step[0] & step[2]) | (step[1] & step[2]);

    assign A_error_ctrl = ctrl[2];
    assign B_error_ctrl = ctrl[1];
    assign C_error_ctrl = ctrl[0];

    always_comb begin
        state_nx    = state;
        step_nx     = step;
        cnt_nx      = cnt;
        seen_err_nx = seen_err;
        seen_bad_nx = seen_bad;
        pass_nx     = pass_mask;
        err_nx      = err_count;
        ctrl_nx     = 3'b000;
        tmr_rst_nx  = 1'b0;
        busy_nx     = busy;
        done_nx     = 1'b0;
        if (abort) begin
            if (state != IDLE) begin
                state_nx    = IDLE;
                busy_nx     = 1'b0;
                seen_err_nx = 1'b0;
                seen_bad_nx = 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nx    = TRST;
                        step_nx     = 3'd0;
                        pass_nx     = 8'h00;
                        err_nx      = '0;
                        seen_err_nx = 1'b0;
                        seen_bad_nx = 1'b0;
                        busy_nx     = 1'b1;
                        tmr_rst_nx  = 1'b1;
                    end
                end
                TRST: begin
                    state_nx = SETTLE;
                    cnt_nx   = '0;
                end
                SETTLE: begin
                    if (cnt == CW'(SETTLE_CYC - 1)) begin
                        state_nx = INJECT;
                        cnt_nx   = '0;
                        ctrl_nx  = step;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                INJECT: begin
                    seen_err_nx = seen_err | tmr_error_in;
                    seen_bad_nx = seen_bad | (tmr_data_in != golden_in);
                    err_nx      = err_count + CNT_W'(tmr_error_in && !(&err_count));
                    if (cnt == CW'(OBS_CYC - 1)) begin
                        state_nx = EVAL;
                    end else begin
                        cnt_nx  = cnt + 1'b1;
                        ctrl_nx = step;
                    end
                end
                EVAL: begin
                    pass_nx[step] = (seen_err == exp_err) && (exp_err || !seen_bad);
                    seen_err_nx   = 1'b0;
                    seen_bad_nx   = 1'b0;
                    if (step == 3'd7) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                        busy_nx  = 1'b0;
                    end else begin
                        step_nx    = step + 3'd1;
                        state_nx   = TRST;
                        tmr_rst_nx = 1'b1;
                    end
                end
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            step      <= 3'd0;
            cnt       <= '0;
            seen_err  <= 1'b0;
            seen_bad  <= 1'b0;
            pass_mask <= 8'h00;
            err_count <= '0;
            ctrl      <= 3'b000;
            tmr_rst   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            step      <= step_nx;
            cnt       <= cnt_nx;
            seen_err  <= seen_err_nx;
            seen_bad  <= seen_bad_nx;
            pass_mask <= pass_nx;
            err_count <= err_nx;
            ctrl      <= ctrl_nx;
            tmr_rst   <= tmr_rst_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end
endmodule

// File: tb/tb_tmr_fault_campaign_ctrl.sv
// tb_tmr_fault_campaign_ctrl: scoreboard bench for the TMR fault campaign sequencer
// with a behavioural TMR unit whose failure mode is selected per campaign.
module tb_tmr_fault_campaign_ctrl;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
    logic [26:0] golden = 27'h0000040;
    logic [26:0] tmr_data;
    logic        tmr_err;
    logic        tmr_rst, a_ctrl, b_ctrl, c_ctrl, busy, done;
    logic [7:0]  pass_mask;
    logic [15:0] err_count;
    logic        tmr_rst4, a4, b4, c4, busy4, done4;
    logic [7:0]  pass4;
    logic [3:0]  err4;
    logic [2:0]  ctrl;
    logic        multi;
    int          mode = 0;
    int          cyc = 0, start_cyc = 0;
    int          passed = 0, total = 0;

    typedef struct {
        logic [7:0]  pass;
        logic [15:0] errc;
        int          lat;
    } exp_t;
    exp_t       q[$];
    logic [3:0] q4[$];

    tmr_fault_campaign_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .golden_in(golden), .tmr_data_in(tmr_data), .tmr_error_in(tmr_err),
        .tmr_rst(tmr_rst), .A_error_ctrl(a_ctrl), .B_error_ctrl(b_ctrl), .C_error_ctrl(c_ctrl),
        .busy(busy), .done(done), .pass_mask(pass_mask), .err_count(err_count)
    );

    tmr_fault_campaign_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .golden_in(golden), .tmr_data_in(golden), .tmr_error_in(1'b1),
        .tmr_rst(tmr_rst4), .A_error_ctrl(a4), .B_error_ctrl(b4), .C_error_ctrl(c4),
        .busy(busy4), .done(done4), .pass_mask(pass4), .err_count(err4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // mode 0: healthy, 1: error flag never raised, 2: data stuck at golden^1 under mask 1
    assign ctrl     = {a_ctrl, b_ctrl, c_ctrl};
    assign multi    = (ctrl == 3'd3) || (ctrl == 3'd5) || (ctrl == 3'd6) || (ctrl == 3'd7);
    assign tmr_err  = (mode != 1) && multi;
    assign tmr_data = multi ? ~golden : (mode == 2 && ctrl == 3'd1) ? golden ^ 27'd1 : golden;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset && done) begin
            if (q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else begin
                e = q.pop_front();
                check("pass_mask", {24'd0, pass_mask}, {24'd0, e.pass});
                check("err_count", {16'd0, err_count}, {16'd0, e.errc});
                check("latency", cyc - start_cyc, e.lat);
                check("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
        if (reset && done4) begin
            if (q4.size() == 0) check("unexpected_done4", 32'd1, 32'd0);
            else check("err_count_sat", {28'd0, err4}, {28'd0, q4.pop_front()});
        end
    end

    task automatic check_zero(input string name);
        check({name, "_outs"}, {26'd0, tmr_rst, ctrl, busy, done}, 32'd0);
        check({name, "_pass"}, {24'd0, pass_mask}, 32'd0);
        check({name, "_err"}, {16'd0, err_count}, 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic run(input int m, input logic [7:0] ep, input logic [15:0] ee, input bit poke);
        int n;
        mode = m;
        q.push_back('{ep, ee, 112});
        q4.push_back(4'hF);
        pulse_start();
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("tmr_rst_pulse", {31'd0, tmr_rst}, 32'd1);
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            start = poke && (n == 30);
        end
        start = 1'b0;
        if (!done) check("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("pass_hold", {24'd0, pass_mask}, {24'd0, ep});
    endtask

    initial begin
        #2 reset = 1'b0;
        #1 check_zero("reset");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        run(0, 8'hFF, 16'd32, 1'b1);
        run(1, 8'h17, 16'd0, 1'b0);
        run(2, 8'hFD, 16'd32, 1'b0);
        mode = 0;
        pulse_start();
        repeat (50) @(negedge clk);
        check("abort_pre_ctrl", {29'd0, ctrl}, 32'd3);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("abort_outs", {26'd0, tmr_rst, ctrl, busy, done}, 32'd0);
        check("abort_pass", {24'd0, pass_mask}, 32'h07);
        check("abort_err", {16'd0, err_count}, 32'd3);
        repeat (20) @(negedge clk);
        check("abort_idle", {31'd0, busy}, 32'd0);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", {31'd0, busy}, 32'd0);
        check("start_abort_pass", {24'd0, pass_mask}, 32'h07);
        pulse_start();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1 check_zero("mid_reset");
        @(negedge clk) reset = 1'b1;
        run(0, 8'hFF, 16'd32, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
